// File: rtl/wavetable_sequencer_pkg.sv
// Shared types and widths for the wavetable sequencer and its readers.
// Latency: none. This file holds declarations only.
// Backpressure: none.
package wavetable_sequencer_pkg;

  // Table index width used by the long-percent tables. This is the default PHASE_WIDTH.
  localparam int LONG_PERCENT_WIDTH = 8;

  // Default number of fractional phase bits below the table index.
  localparam int INCREMENT_FRAC_WIDTH = 16;

  // Oscillator state. In IDLE the reader must output 0.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    BACK  = 2'd2
  } oscillator_state_t;

endpackage

// File: rtl/wavetable_sequencer_phase_accumulator.sv
// Phase accumulator: holds acc and exposes carry of acc + increment.
// Latency: acc updates 1 cycle after clear_i or step_i.
// Backpressure: none. clear_i has priority over step_i.
module wavetable_sequencer_phase_accumulator #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] increment_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   sum;

  // The sum is one bit wider than acc. Its top bit marks a table wrap.
  assign sum     = {1'b0, acc_q} + {1'b0, increment_i};
  assign carry_o = sum[WIDTH];
  assign acc_o   = acc_q;

  // Next value. A wrap keeps the low remainder so the phase stays continuous.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[WIDTH-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/wavetable_sequencer.sv
// Voice sequencer: plays FRONT once, then loops BACK. Release is taken only on a BACK wrap.
// Latency: tick at t gives new state/phase at t+1 and sample_strobe at t+2.
// Backpressure: none. note pulses act in the cycle they arrive, independent of tick.
module wavetable_sequencer
  import wavetable_sequencer_pkg::*;
#(
  parameter int PHASE_WIDTH = LONG_PERCENT_WIDTH,
  parameter int FRAC_WIDTH  = INCREMENT_FRAC_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            note_on,
  input  logic                            note_off,
  input  logic [PHASE_WIDTH+FRAC_WIDTH-1:0] increment,
  output oscillator_state_t               state,
  output logic [PHASE_WIDTH-1:0]          phase,
  output logic                            active,
  output logic                            sample_strobe
);

  localparam int ACC_WIDTH = PHASE_WIDTH + FRAC_WIDTH;

  oscillator_state_t      state_q;
  logic                   stop_pending_q;
  logic [1:0]             strobe_q;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   carry;
  logic                   acc_clear;
  logic                   acc_step;

  // Accumulator control. A retrigger or a release wrap zeroes the phase.
  // Every other tick while sounding advances it.
  assign acc_clear = note_on | (tick & (state_q == BACK) & carry & stop_pending_q);
  assign acc_step  = tick & (state_q != IDLE);

  wavetable_sequencer_phase_accumulator #(
    .WIDTH (ACC_WIDTH)
  ) u_acc (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (acc_clear),
    .step_i      (acc_step),
    .increment_i (increment),
    .acc_o       (acc),
    .carry_o     (carry)
  );

  // Oscillator FSM and release request. note_on overrides everything except reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      stop_pending_q <= 1'b0;
    end else if (note_on) begin
      state_q        <= FRONT;
      stop_pending_q <= 1'b0;
    end else begin
      if (note_off && (state_q != IDLE)) begin
        stop_pending_q <= 1'b1;
      end
      if (tick) begin
        case (state_q)
          FRONT: begin
            if (carry) begin
              state_q <= BACK;
            end
          end
          BACK: begin
            if (carry && stop_pending_q) begin
              state_q        <= IDLE;
              stop_pending_q <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Two-stage tick delay. It lines the strobe up with the reader's registered sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q <= 2'b00;
    end else begin
      strobe_q <= {strobe_q[0], tick};
    end
  end

  assign state         = state_q;
  assign phase         = acc[ACC_WIDTH-1:FRAC_WIDTH];
  assign active        = (state_q != IDLE);
  assign sample_strobe = strobe_q[1];

endmodule

// File: tb/tb_wavetable_sequencer.sv
// Self-checking bench for wavetable_sequencer with a 16-entry table and 4 fractional bits.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_wavetable_sequencer;
  import wavetable_sequencer_pkg::*;

  localparam int PW = 4;
  localparam int FW = 4;
  localparam int FULL = 256;   // 2^(PW+FW)

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              tick = 1'b0;
  logic              note_on = 1'b0;
  logic              note_off = 1'b0;
  logic [PW+FW-1:0]  increment = '0;
  oscillator_state_t state;
  logic [PW-1:0]     phase;
  logic              active;
  logic              sample_strobe;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always #5 clock = ~clock;

  wavetable_sequencer #(
    .PHASE_WIDTH (PW),
    .FRAC_WIDTH  (FW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .note_on       (note_on),
    .note_off      (note_off),
    .increment     (increment),
    .state         (state),
    .phase         (phase),
    .active        (active),
    .sample_strobe (sample_strobe)
  );

  // Behavioural model. The note state is a named state, the phase is an integer
  // position, and the strobe is a two-entry tick history.
  oscillator_state_t m_state = IDLE;
  int                m_pos = 0;
  bit                m_release = 1'b0;
  bit                m_tick_d1 = 1'b0;
  bit                m_tick_d2 = 1'b0;
  bit                chk_en = 1'b0;

  always @(posedge clock) begin
    bit was_release;
    int next_pos;
    cycle++;
    was_release = m_release;
    if (reset) begin
      m_state = IDLE; m_pos = 0; m_release = 0; m_tick_d1 = 0; m_tick_d2 = 0;
      chk_en = 1'b1;
    end else begin
      m_tick_d2 = m_tick_d1;
      m_tick_d1 = tick;
      if (note_on) begin
        m_state = FRONT; m_pos = 0; m_release = 0;
      end else begin
        if (note_off && m_state != IDLE) m_release = 1;
        if (tick && m_state != IDLE) begin
          next_pos = m_pos + int'(increment);
          if (next_pos >= FULL) begin
            // A whole table has been played.
            if (m_state == FRONT) begin
              m_state = BACK; m_pos = next_pos - FULL;
            end else if (was_release) begin
              m_state = IDLE; m_pos = 0; m_release = 0;
            end else begin
              m_pos = next_pos - FULL;
            end
          end else begin
            m_pos = next_pos;
          end
        end
      end
    end
  end

  // Compare every output against the model on every cycle, away from the clock edge.
  always @(negedge clock) begin
    if (chk_en) begin
      tests++;
      if (state !== m_state || phase !== 4'(m_pos / 16) ||
          active !== (m_state != IDLE) || sample_strobe !== m_tick_d2) begin
        fails++;
        $display("FAIL model cyc=%0d got st=%0d ph=%0d act=%0b stb=%0b need st=%0d ph=%0d act=%0b stb=%0b",
                 cycle, state, phase, active, sample_strobe,
                 m_state, m_pos / 16, (m_state != IDLE), m_tick_d2);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit t, input bit on, input bit off);
    tick = t; note_on = on; note_off = off;
    @(posedge clock);
    #1;
    tick = 0; note_on = 0; note_off = 0;
  endtask

  // Each tick is followed by one quiet cycle.
  task automatic ticks(input int n);
    repeat (n) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  initial begin
    // Reset, then run ticks while IDLE.
    reset = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 0;
    ticks(3);
    check_lit("idle_state", int'(state), int'(IDLE));
    check_lit("idle_phase", int'(phase), 0);
    check_lit("idle_active", int'(active), 0);

    // One full FRONT pass with unit steps, then loop BACK.
    increment = 8'h10;
    step(0, 1, 0);
    check_lit("on_state", int'(state), int'(FRONT));
    ticks(15);
    check_lit("front_ph15", int'(phase), 15);
    ticks(1);
    check_lit("to_back_state", int'(state), int'(BACK));
    check_lit("to_back_phase", int'(phase), 0);
    ticks(20);
    check_lit("back_loop_ph4", int'(phase), 4);

    // The wrap keeps the remainder. 0xF0+0x18 gives frac 8; the next 0x18 step gives phase 2.
    step(0, 1, 0);
    ticks(15);
    increment = 8'h18;
    ticks(1);
    check_lit("rem_back", int'(state), int'(BACK));
    check_lit("rem_phase0", int'(phase), 0);
    ticks(1);
    check_lit("rem_phase2", int'(phase), 2);

    // Release in BACK at phase 5. It completes the cycle, then goes IDLE.
    increment = 8'h10;
    ticks(3);
    check_lit("rel_ph5", int'(phase), 5);
    step(0, 0, 1);
    ticks(10);
    check_lit("rel_still_back", int'(state), int'(BACK));
    check_lit("rel_ph15", int'(phase), 15);
    ticks(1);
    check_lit("rel_idle", int'(state), int'(IDLE));
    check_lit("rel_inactive", int'(active), 0);

    // Release during FRONT. FRONT finishes, one full BACK cycle plays, then IDLE.
    step(0, 1, 0);
    ticks(3);
    step(0, 0, 1);
    ticks(13);
    check_lit("frel_back", int'(state), int'(BACK));
    ticks(15);
    check_lit("frel_back15", int'(phase), 15);
    ticks(1);
    check_lit("frel_idle", int'(state), int'(IDLE));

    // note_on and note_off together in BACK. Retrigger wins and no release follows.
    step(0, 1, 0);
    ticks(21);
    step(0, 1, 1);
    check_lit("onoff_front", int'(state), int'(FRONT));
    check_lit("onoff_ph0", int'(phase), 0);
    ticks(56);
    check_lit("onoff_loops", int'(state), int'(BACK));
    check_lit("onoff_ph8", int'(phase), 8);
    reset = 1;
    step(0, 0, 0);
    reset = 0;
    check_lit("rst_mid_idle", int'(state), int'(IDLE));

    // note_off in IDLE is ignored. note_on with a coincident tick does not accumulate.
    step(0, 0, 1);
    step(1, 1, 0);
    check_lit("on_tick_ph0", int'(phase), 0);
    ticks(30);
    check_lit("no_stale_rel", int'(state), int'(BACK));

    // Zero increment holds the phase. Back-to-back ticks exercise the strobe pipe.
    increment = 8'h00;
    ticks(5);
    check_lit("inc0_hold", int'(phase), 14);
    increment = 8'h10;
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_lit("b2b_ph2", int'(phase), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wavetable_sequencer.md
Name: wavetable_sequencer

Overview:
- Drives the wavetable reader: produces the oscillator state (IDLE/FRONT/BACK) and the table phase that select one sample per tick.
- Plays the FRONT (attack) table once, then loops the BACK (sustain) table until release.
- Stops on a BACK loop boundary so note-off never truncates a cycle mid-waveform.
- Sits between the voice/MIDI note logic and the per-instrument wavetable readers; one instance per voice.

Parameters:
- PHASE_WIDTH, CONFIG::LONG_PERCENT_WIDTH: table index width; table length is 2^PHASE_WIDTH.
- FRAC_WIDTH, 16: fractional accumulator bits below the index.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  sample-rate enable, one-cycle pulse
- note_on  in  1  one-cycle pulse; start/retrigger
- note_off  in  1  one-cycle pulse; request release
- increment  in  PHASE_WIDTH+FRAC_WIDTH  phase step per tick (pitch), sampled every tick
- state  out  OSCILLATOR::oscillator_state_t  IDLE, FRONT or BACK; registered
- phase  out  PHASE_WIDTH  accumulator[top PHASE_WIDTH bits]; registered
- active  out  1  state != IDLE
- sample_strobe  out  1  tick delayed 2 cycles; aligns with the reader's registered table output

Behaviour:
- Accumulator acc is PHASE_WIDTH+FRAC_WIDTH bits. Next value is sum = acc + increment, computed one bit wider; carry is the top bit.
- Reset: state=IDLE, acc=0, phase=0, active=0, sample_strobe=0, stop_pending=0, strobe pipe cleared. Reset mid-note aborts immediately, with no drain.
- note_on and note_off are acted on in the cycle they are asserted, independent of tick.
  - note_on: state<=FRONT, acc<=0, stop_pending<=0. Applies in any state, including retrigger from FRONT/BACK.
  - note_off in FRONT or BACK: stop_pending<=1. Ignored in IDLE.
  - note_on and note_off in the same cycle: note_on wins and stop_pending stays 0.
  - note_on coincident with tick: retrigger applies; no accumulate that cycle.
- On tick, with no note_on in the same cycle:
  - IDLE: nothing changes.
  - FRONT, no carry: acc<=sum[low].
  - FRONT, carry, stop_pending=0: state<=BACK, acc<=sum[low]. The wrapped remainder is kept so phase stays continuous.
  - FRONT, carry, stop_pending=1: state<=BACK, acc<=sum[low]. Stop is then taken at the first BACK wrap.
  - BACK, no carry: acc<=sum[low].
  - BACK, carry, stop_pending=0: acc<=sum[low] (loop).
  - BACK, carry, stop_pending=1: state<=IDLE, acc<=0, stop_pending<=0.
- Latency: tick at cycle t produces new state/phase at t+1; the reader registers the sample at t+2; sample_strobe is high at t+2.
- increment=0: phase holds and state never advances; no error is raised.
- An increment ≥ one full table (integer part ≥ 2^PHASE_WIDTH) is impossible by width. At most one carry occurs per tick.
- sample_strobe follows tick in every state, including IDLE, so the mixer keeps its cadence. The reader output is don't-care when active=0; the mixer gates on active.

Decomposition:
- OSCILLATOR package: add IDLE to oscillator_state_t, next to FRONT and BACK. The reader must treat IDLE as output 0; the package owner makes that update.
- CONFIG package: supplies LONG_PERCENT_WIDTH. Add INCREMENT_FRAC_WIDTH=16 as the shared default for FRAC_WIDTH.
- Sub-module phase_accumulator: holds acc and produces sum/carry, with a clear/load-remainder control.
- wavetable_sequencer: owns the FSM, stop_pending, and the strobe pipe.

Test Plan (PHASE_WIDTH=4, FRAC_WIDTH=4, 16-entry table):
- Reset then 3 ticks → state=IDLE, phase=0, active=0; sample_strobe pulses 2 cycles after each tick.
- note_on, increment=0x10, 16 ticks → phase steps 0..15 in FRONT. The 16th tick sets state=BACK, phase=0. The next ticks loop 0..15 repeatedly.
- increment=0x18 from FRONT phase 15, frac 0 → carry; state=BACK, phase=0, frac=8 (remainder kept). Next tick → phase=2, frac=0.
- In BACK at phase 5 (increment=0x10), note_off → state stays BACK through phase 15; the next tick gives IDLE, phase=0, active=0.
- note_off during FRONT at phase 3 → FRONT completes, passes through one full BACK cycle 0..15, then IDLE.
- note_on and note_off in the same cycle while in BACK → state=FRONT, phase=0, no release; later BACK loops indefinitely. Separately, reset asserted mid-BACK → IDLE next cycle.
